// File: rtl/regfile_access_pkg.sv
// Shared types and constants for the register-file access master.
package regfile_access_pkg;

  localparam int NBIT           = 64;
  localparam int NADDR          = 4;
  localparam int RAS_RD_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_CAPTURE,
    RESP
  } ras_state_e;

  typedef struct packed {
    logic             wr;
    logic [NADDR-1:0] addr;
    logic [NBIT-1:0]  data;
  } ras_req_t;

endpackage

// File: rtl/regfile_access_master.sv
// Valid/ready bus initiator driving the register file's single-port pins.
// Optional build macro RF_WRITE_VERIFY_EN: read back every write and flag mismatches.
module regfile_access_master
  import regfile_access_pkg::*;
#(
  parameter int NBIT  = 64,
  parameter int NREG  = 16,
  parameter int NADDR = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WR,
  input  logic [NADDR-1:0] REQ_ADDR,
  input  logic [NBIT-1:0]  REQ_DATA,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [NBIT-1:0]  RSP_DATA,
  output logic             RSP_ERR,
  output logic             RF_ENABLE,
  output logic             RF_WR,
  output logic [NADDR-1:0] RF_ADDR,
  output logic [NBIT-1:0]  RF_DATAIN,
  input  logic [NBIT-1:0]  RF_OUT1,
  output logic [CNT_W-1:0] TXN_COUNT
);

  // One extra bit so NREG == 2**NADDR still compares correctly.
  localparam logic [NADDR:0] NREG_LIM = (NADDR + 1)'(NREG);

  ras_state_e       state, state_next;
  logic [NBIT-1:0]  req_data_reg, req_data_next;
  logic             req_ready_next;
  logic             rsp_valid_next;
  logic [NBIT-1:0]  rsp_data_next;
  logic             rsp_err_next;
  logic             rf_enable_next;
  logic             rf_wr_next;
  logic [NADDR-1:0] rf_addr_next;
  logic [NBIT-1:0]  rf_datain_next;
  logic [CNT_W-1:0] txn_count_next;
  logic             out_of_range;
`ifdef RF_WRITE_VERIFY_EN
  logic             req_wr_reg, req_wr_next;
`endif

  assign out_of_range = ({1'b0, REQ_ADDR} >= NREG_LIM);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      req_data_reg <= '0;
      REQ_READY    <= 1'b0;
      RSP_VALID    <= 1'b0;
      RSP_DATA     <= '0;
      RSP_ERR      <= 1'b0;
      RF_ENABLE    <= 1'b0;
      RF_WR        <= 1'b0;
      RF_ADDR      <= '0;
      RF_DATAIN    <= '0;
      TXN_COUNT    <= '0;
`ifdef RF_WRITE_VERIFY_EN
      req_wr_reg   <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      req_data_reg <= req_data_next;
      REQ_READY    <= req_ready_next;
      RSP_VALID    <= rsp_valid_next;
      RSP_DATA     <= rsp_data_next;
      RSP_ERR      <= rsp_err_next;
      RF_ENABLE    <= rf_enable_next;
      RF_WR        <= rf_wr_next;
      RF_ADDR      <= rf_addr_next;
      RF_DATAIN    <= rf_datain_next;
      TXN_COUNT    <= txn_count_next;
`ifdef RF_WRITE_VERIFY_EN
      req_wr_reg   <= req_wr_next;
`endif
    end
  end

  // Outputs are computed for the state being entered, so they appear registered.
  always_comb begin
    state_next     = state;
    req_data_next  = req_data_reg;
    rsp_valid_next = RSP_VALID;
    rsp_data_next  = RSP_DATA;
    rsp_err_next   = RSP_ERR;
    rf_enable_next = 1'b0;
    rf_wr_next     = 1'b0;
    rf_addr_next   = RF_ADDR;
    rf_datain_next = RF_DATAIN;
    txn_count_next = TXN_COUNT;
`ifdef RF_WRITE_VERIFY_EN
    req_wr_next    = req_wr_reg;
`endif

    case (state)
      IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          req_data_next = REQ_DATA;
`ifdef RF_WRITE_VERIFY_EN
          req_wr_next   = REQ_WR;
`endif
          if (out_of_range) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_data_next  = '0;
            rsp_err_next   = 1'b1;
          end else begin
            rf_enable_next = 1'b1;
            rf_addr_next   = REQ_ADDR;
            if (REQ_WR) begin
              state_next     = WRITE;
              rf_wr_next     = 1'b1;
              rf_datain_next = REQ_DATA;
            end else begin
              state_next = RD_ISSUE;
            end
          end
        end
      end
      WRITE: begin
`ifdef RF_WRITE_VERIFY_EN
        state_next     = RD_ISSUE;
        rf_enable_next = 1'b1;
`else
        state_next     = RESP;
        rsp_valid_next = 1'b1;
        rsp_data_next  = req_data_reg;
        rsp_err_next   = 1'b0;
`endif
      end
      RD_ISSUE: state_next = RD_CAPTURE;
      RD_CAPTURE: begin
        // RF_OUT1 is valid here because the RF registers its read one cycle after ENABLE.
        state_next     = RESP;
        rsp_valid_next = 1'b1;
        rsp_data_next  = RF_OUT1;
`ifdef RF_WRITE_VERIFY_EN
        rsp_err_next   = req_wr_reg && (RF_OUT1 != req_data_reg);
`else
        rsp_err_next   = 1'b0;
`endif
      end
      RESP: begin
        if (RSP_READY) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          txn_count_next = TXN_COUNT + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    req_ready_next = (state_next == IDLE);
  end

endmodule

// File: tb/tb_regfile_access_master.sv
// Directed bench for regfile_access_master with a behavioural register file model.
// Build with RF_WRITE_VERIFY_EN defined to exercise the write-verify path.
module tb_regfile_access_master;

`ifdef RF_WRITE_VERIFY_EN
  localparam int  WR_LAT    = 4;
  localparam bit  VERIFY_ON = 1'b1;
`else
  localparam int  WR_LAT    = 2;
  localparam bit  VERIFY_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WR = 1'b0;
  logic [3:0]  REQ_ADDR = '0;
  logic [63:0] REQ_DATA = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [63:0] RSP_DATA;
  logic        RSP_ERR;
  logic        RF_ENABLE;
  logic        RF_WR;
  logic [3:0]  RF_ADDR;
  logic [63:0] RF_DATAIN;
  logic [63:0] RF_OUT1;
  logic [3:0]  TXN_COUNT;

  regfile_access_master #(.NBIT(64), .NREG(12), .NADDR(4), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .RF_ENABLE(RF_ENABLE), .RF_WR(RF_WR), .RF_ADDR(RF_ADDR), .RF_DATAIN(RF_DATAIN),
    .RF_OUT1(RF_OUT1), .TXN_COUNT(TXN_COUNT)
  );

  always #5 CLK = ~CLK;

  // Register file model: registered write and registered read; address 7 has a stuck bit 0.
  logic [63:0] rf_mem [16];
  always @(posedge CLK) begin
    if (RF_ENABLE) begin
      if (RF_WR) rf_mem[RF_ADDR] <= (RF_ADDR == 4'd7) ? (RF_DATAIN ^ 64'd1) : RF_DATAIN;
      else       RF_OUT1 <= rf_mem[RF_ADDR];
    end
  end

  int wr_pulses = 0, wr_run = 0, wr_max_run = 0, en_cycles = 0;
  always @(negedge CLK) begin
    if (RF_ENABLE) en_cycles++;
    if (RF_WR) begin
      if (wr_run == 0) wr_pulses++;
      wr_run++;
      if (wr_run > wr_max_run) wr_max_run = wr_run;
    end else begin
      wr_run = 0;
    end
  end

  int         n_assert = 0;
  int         n_fail = 0;
  logic [3:0] exp_count = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for REQ_READY, presents one request for a single accept edge, then scrambles the inputs.
  task automatic send(input string tag, input logic wr, input logic [3:0] addr, input logic [63:0] data);
    int w = 0;
    while (REQ_READY !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk({tag, "_req_ready"}, 64'(REQ_READY), 64'd1);
    REQ_VALID = 1'b1;
    REQ_WR    = wr;
    REQ_ADDR  = addr;
    REQ_DATA  = data;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    REQ_WR    = ~wr;
    REQ_ADDR  = ~addr;
    REQ_DATA  = ~data;
  endtask

  task automatic txn(input string tag, input logic wr, input logic [3:0] addr, input logic [63:0] data,
                     input int exp_lat, input logic [63:0] exp_data, input logic exp_err, input int hold);
    int lat = 1;
    RSP_READY = 1'b0;
    send(tag, wr, addr, data);
    while (RSP_VALID !== 1'b1 && lat < 12) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, RSP_DATA, exp_data);
    chk({tag, "_err"}, 64'(RSP_ERR), 64'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk({tag, "_hold_valid"}, 64'(RSP_VALID), 64'd1);
      chk({tag, "_hold_data"}, RSP_DATA, exp_data);
      chk({tag, "_hold_req_ready"}, 64'(REQ_READY), 64'd0);
      chk({tag, "_hold_count"}, 64'(TXN_COUNT), 64'(exp_count));
    end
    RSP_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RSP_READY = 1'b0;
    exp_count = exp_count + 4'd1;
    chk({tag, "_count"}, 64'(TXN_COUNT), 64'(exp_count));
    chk({tag, "_rsp_drop"}, 64'(RSP_VALID), 64'd0);
    $display("txn %s wr=%0d addr=%0d lat=%0d data=%0h err=%0d count=%0d",
             tag, wr, addr, lat, RSP_DATA, RSP_ERR, TXN_COUNT);
  endtask

  initial begin
    int en_before;
    int pulses_before;
    int stray;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", 64'(REQ_READY), 64'd0);
    chk("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("rst_rsp_data", RSP_DATA, 64'd0);
    chk("rst_rsp_err", 64'(RSP_ERR), 64'd0);
    chk("rst_rf_enable", 64'(RF_ENABLE), 64'd0);
    chk("rst_rf_wr", 64'(RF_WR), 64'd0);
    chk("rst_rf_addr", 64'(RF_ADDR), 64'd0);
    chk("rst_rf_datain", RF_DATAIN, 64'd0);
    chk("rst_txn_count", 64'(TXN_COUNT), 64'd0);
    RESET = 1'b0;

    // Write then read back
    txn("wr3", 1'b1, 4'd3, 64'hDEADBEEF_0000_0001, WR_LAT, 64'hDEADBEEF_0000_0001, 1'b0, 0);
    txn("rd3", 1'b0, 4'd3, 64'h0, 3, 64'hDEADBEEF_0000_0001, 1'b0, 0);

    // Read with response backpressure
    txn("wr5", 1'b1, 4'd5, 64'h1234_5678_9ABC_DEF0, WR_LAT, 64'h1234_5678_9ABC_DEF0, 1'b0, 0);
    txn("rd5_bp", 1'b0, 4'd5, 64'h0, 3, 64'h1234_5678_9ABC_DEF0, 1'b0, 5);

    // Out-of-range addresses never touch the RF
    en_before = en_cycles;
    txn("rd13_oor", 1'b0, 4'd13, 64'h0, 1, 64'h0, 1'b1, 0);
    txn("wr12_oor", 1'b1, 4'd12, 64'hFFFF, 1, 64'h0, 1'b1, 0);
    chk("oor_no_enable", 64'(en_cycles - en_before), 64'd0);
    txn("wr11_edge", 1'b1, 4'd11, 64'h0BAD_F00D, WR_LAT, 64'h0BAD_F00D, 1'b0, 0);

    // Reset during a write: the RF write strobe drops without waiting for a clock
    send("abort_wr", 1'b1, 4'd3, 64'h1111_2222_3333_4444);
    chk("abort_wr_rf_wr_before", 64'(RF_WR), 64'd1);
    RESET = 1'b1;
    #1;
    chk("abort_wr_rf_wr", 64'(RF_WR), 64'd0);
    chk("abort_wr_rf_enable", 64'(RF_ENABLE), 64'd0);
    chk("abort_wr_count", 64'(TXN_COUNT), 64'd0);
    exp_count = '0;
    @(negedge CLK);
    RESET = 1'b0;

    // Reset during RD_CAPTURE
    send("abort_rd", 1'b0, 4'd3, 64'h0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("abort_rd_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("abort_rd_rf_enable", 64'(RF_ENABLE), 64'd0);
    chk("abort_rd_rsp_data", RSP_DATA, 64'd0);
    chk("abort_rd_req_ready", 64'(REQ_READY), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (RSP_VALID !== 1'b0) stray++;
    end
    chk("abort_no_rsp", 64'(stray), 64'd0);
    txn("rd3_after_rst", 1'b0, 4'd3, 64'h0, 3, 64'hDEADBEEF_0000_0001, 1'b0, 0);

    // Counter wrap: 15 more writes take the 4-bit count from 1 back to 0
    pulses_before = wr_pulses;
    for (int i = 0; i < 15; i++) begin
      txn("wr_wrap", 1'b1, 4'(i % 6), 64'(i + 100), WR_LAT, 64'(i + 100), 1'b0, 0);
    end
    chk("wrap_count_zero", 64'(TXN_COUNT), 64'd0);
    txn("wr_wrap_last", 1'b1, 4'd2, 64'hCAFE, WR_LAT, 64'hCAFE, 1'b0, 0);
    chk("wrap_pulses", 64'(wr_pulses - pulses_before), 64'd16);
    chk("wr_pulse_width", 64'(wr_max_run), 64'd1);

    // Stuck bit at address 7 is only visible with write verify
    txn("wr7", 1'b1, 4'd7, 64'hA5, WR_LAT, VERIFY_ON ? 64'hA4 : 64'hA5, VERIFY_ON, 0);
    txn("wr6", 1'b1, 4'd6, 64'hA5, WR_LAT, 64'hA5, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
